// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall controller.
package pipe_stall_ctrl_pkg;

   localparam int unsigned DEF_MAX_WAIT = 64;
   localparam int unsigned DEF_CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall-source inputs, pipeline control outputs and performance counters.
interface pipe_stall_ctrl_if import pipe_stall_ctrl_pkg::*; #(
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   logic             hazard_detected;
   logic             branch_taken;
   logic             mem_req;
   logic             sram_ready;
   logic             perf_clr;

   logic             freeze_pc;
   logic             freeze_if_id;
   logic             freeze_id_exe;
   logic             freeze_exe_mem;
   logic             flush_if_id;
   logic             flush_id_exe;
   logic             bubble_id_exe;
   logic             bubble_mem_wb;
   logic             mem_timeout;

   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] hazard_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline side: supplies stall sources, consumes control.
   modport master (
      output hazard_detected, branch_taken, mem_req, sram_ready, perf_clr,
      input  freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
      input  flush_if_id, flush_id_exe, bubble_id_exe, bubble_mem_wb,
      input  mem_timeout, stall_cnt, hazard_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  hazard_detected, branch_taken, mem_req, sram_ready, perf_clr,
      output freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
      output flush_if_id, flush_id_exe, bubble_id_exe, bubble_mem_wb,
      output mem_timeout, stall_cnt, hazard_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up by one per cycle, hold at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central freeze/flush/bubble control with memory-wait watchdog and perf counters.
module pipe_stall_ctrl import pipe_stall_ctrl_pkg::*; #(
   parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stall_ctrl_if.slave  bus
);

   localparam int unsigned WAIT_W    = $clog2(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_e            state;
   logic [WAIT_W-1:0] wait_cnt;

   logic err;
   logic mem_stall;
   logic br_flush;
   logic haz_stall;
   logic freeze_front;
   logic freeze_back;

   // Stall sources in priority order: error, memory wait, branch flush, hazard.
   always_comb begin
      err          = 1'b0;
      mem_stall    = 1'b0;
      br_flush     = 1'b0;
      haz_stall    = 1'b0;
      freeze_front = 1'b0;
      freeze_back  = 1'b0;
      if (!rst) begin
         err          = (state == ST_ERR);
         mem_stall    = bus.mem_req && !bus.sram_ready && !err;
         br_flush     = bus.branch_taken && !mem_stall && !err;
         haz_stall    = bus.hazard_detected && !bus.branch_taken && !mem_stall && !err;
         freeze_front = mem_stall || haz_stall || err;
         freeze_back  = mem_stall || err;
      end
   end

   // Zero-latency control fan-out; a taken branch never freezes the PC.
   always_comb begin
      bus.freeze_pc      = freeze_front;
      bus.freeze_if_id   = freeze_front;
      bus.freeze_id_exe  = freeze_back;
      bus.freeze_exe_mem = freeze_back;
      bus.bubble_mem_wb  = freeze_back;
      bus.bubble_id_exe  = haz_stall;
      bus.flush_if_id    = br_flush;
      bus.flush_id_exe   = br_flush;
      bus.mem_timeout    = err;
   end

   // Memory-wait FSM; ERR is only left through reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mem_stall) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (bus.sram_ready || !bus.mem_req) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= ST_ERR;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_ERR: begin
               state <= ST_ERR;
            end
            default: begin
               state    <= ST_RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.perf_clr),
      .inc   (freeze_front),
      .count (bus.stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.perf_clr),
      .inc   (haz_stall),
      .count (bus.hazard_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.perf_clr),
      .inc   (br_flush),
      .count (bus.flush_cnt)
   );

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer side of the pipeline hazard/forwarding interface. Takes the hazard-detected flag, the branch-taken signal from EXE and the SRAM ready/request pair from MEM.
- Drives every pipeline-register freeze, flush and bubble control from a single point, and resolves priority between these stall sources.
- Contains a memory-wait state machine with a timeout watchdog, plus saturating performance counters.
- Sits beside the hazard unit in the top-level ARM pipeline.

Parameters:
- MAX_WAIT, 64, consecutive SRAM wait cycles tolerated before timeout (≥2)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- hazard_detected  in  1  RAW hazard from hazard unit (ID stage)
- branch_taken  in  1  branch resolved taken in EXE
- mem_req  in  1  MEM stage has MEM_R_EN or MEM_W_EN set
- sram_ready  in  1  SRAM controller completes the access this cycle
- perf_clr  in  1  synchronous clear of the performance counters
- freeze_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID register
- freeze_id_exe  out  1  hold ID/EXE register
- freeze_exe_mem  out  1  hold EXE/MEM register
- flush_if_id  out  1  clear IF/ID on the next edge
- flush_id_exe  out  1  clear ID/EXE on the next edge
- bubble_id_exe  out  1  load ID/EXE with zeroed control bits
- bubble_mem_wb  out  1  load MEM/WB with WB_EN=0
- mem_timeout  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  cycles with freeze_pc=1
- hazard_cnt  out  CNT_W  cycles with a hazard-induced bubble
- flush_cnt  out  CNT_W  branch flush events

Behaviour:
- States:
  - RUN
  - MEM_WAIT
  - ERR
- Reset values:
  - state=RUN, wait_cnt=0, all counters 0, mem_timeout=0.
  - All control outputs are 0 while rst=1.
- Internal terms:
  - mem_stall = mem_req && !sram_ready && state!=ERR
  - err = (state==ERR)
  - br_flush = branch_taken && !mem_stall && !err
  - haz_stall = hazard_detected && !branch_taken && !mem_stall && !err
- Control outputs are combinational from the current state and inputs, so the stall takes effect in the same cycle (zero latency):
  - freeze_pc = freeze_if_id = mem_stall || haz_stall || err
  - freeze_id_exe = freeze_exe_mem = mem_stall || err
  - bubble_mem_wb = mem_stall || err
  - bubble_id_exe = haz_stall
  - flush_if_id = flush_id_exe = br_flush
- Priority: ERR > memory wait > branch flush > hazard. A branch never freezes the PC, because the PC must load the branch target.
- RUN:
  - Go to MEM_WAIT when mem_stall; wait_cnt←1.
  - A single-cycle ready (mem_req && sram_ready) stays in RUN.
- MEM_WAIT:
  - sram_ready → RUN, wait_cnt←0.
  - mem_req dropped → RUN.
  - Otherwise, wait_cnt==MAX_WAIT-1 → ERR.
  - Otherwise, wait_cnt←wait_cnt+1.
- ERR:
  - mem_timeout=1 and the full freeze is held until rst.
  - sram_ready does not exit ERR.
- Counters:
  - Each counter increments at most 1 per cycle and saturates at all-ones (no wrap).
  - perf_clr wins over a simultaneous increment.
  - flush_cnt counts cycles with br_flush=1.
- rst asserted mid-wait: everything returns to reset values on that edge; a pending SRAM access is the SRAM controller's concern.
- Inputs are sampled only at the rising clk edge; no reliance on input ordering within a cycle.

Decomposition:
- Shared package: state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the default MAX_WAIT/CNT_W constants.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
- Reset release, all inputs 0 → every control output 0, counters 0, state RUN.
- hazard_detected=1 for 2 cycles → freeze_pc/freeze_if_id/bubble_id_exe=1 both cycles, freeze_id_exe=0, hazard_cnt=2, stall_cnt=2.
- hazard_detected=1 and branch_taken=1 together → flush_if_id=flush_id_exe=1, freeze_pc=0, bubble_id_exe=0, flush_cnt=1, hazard_cnt unchanged.
- mem_req=1, sram_ready=0 for 5 cycles then 1 with branch_taken=1 throughout → all four freezes and bubble_mem_wb=1 for 5 cycles, no flush; state RUN on the ready cycle, then the flush fires; stall_cnt=5.
- MAX_WAIT=4, mem_req=1, sram_ready never asserted → ERR entered after 4 wait cycles, mem_timeout=1 sticky; a later sram_ready=1 leaves it set; rst clears it.
- CNT_W=3, hazard held 10 cycles → hazard_cnt saturates at 7; perf_clr with hazard still asserted → 0 next cycle, then counts resume.
